// File: rtl/axis_noc_pkg.sv
// rtl/axis_noc_pkg.sv - arbiter state encoding and round-robin index helper
package axis_noc_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/axis_packet_arbiter_if.sv
// rtl/axis_packet_arbiter_if.sv - requester-side and output-side AXIS signals of the arbiter
interface axis_packet_arbiter_if #(
  parameter int NUM_INPUTS  = 4,
  parameter int TDATA_WIDTH = 32,
  parameter int TDEST_WIDTH = 2,
  parameter int TID_WIDTH   = 2
);

  logic [NUM_INPUTS-1:0]  axis_in_tvalid;
  logic [NUM_INPUTS-1:0]  axis_in_tready;
  logic [TDATA_WIDTH-1:0] axis_in_tdata [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]  axis_in_tlast;
  logic [TID_WIDTH-1:0]   axis_in_tid   [NUM_INPUTS];
  logic [TDEST_WIDTH-1:0] axis_in_tdest [NUM_INPUTS];

  logic                   axis_out_tvalid;
  logic                   axis_out_tready;
  logic [TDATA_WIDTH-1:0] axis_out_tdata;
  logic                   axis_out_tlast;
  logic [TID_WIDTH-1:0]   axis_out_tid;
  logic [TDEST_WIDTH-1:0] axis_out_tdest;

  // Arbiter side: sink of the requester streams, source of the merged stream.
  modport slave (
    input  axis_in_tvalid, axis_in_tdata, axis_in_tlast, axis_in_tid, axis_in_tdest,
    output axis_in_tready,
    output axis_out_tvalid, axis_out_tdata, axis_out_tlast, axis_out_tid, axis_out_tdest,
    input  axis_out_tready
  );

  modport master (
    output axis_in_tvalid, axis_in_tdata, axis_in_tlast, axis_in_tid, axis_in_tdest,
    input  axis_in_tready,
    input  axis_out_tvalid, axis_out_tdata, axis_out_tlast, axis_out_tid, axis_out_tdest,
    output axis_out_tready
  );

endinterface

// File: rtl/axis_rr_select.sv
// rtl/axis_rr_select.sv - combinational round-robin winner search starting after the last winner
module axis_rr_select
  import axis_noc_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int IDX_WIDTH  = 2
) (
  input  logic [NUM_INPUTS-1:0] i_valid,
  input  logic [IDX_WIDTH-1:0]  i_last,
  output logic [IDX_WIDTH-1:0]  o_winner,
  output logic                  o_any
);

  always_comb begin
    int unsigned v_idx;
    logic        v_found;
    v_found  = 1'b0;
    o_winner = '0;
    v_idx    = rr_next(32'(i_last), NUM_INPUTS);
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (!v_found && i_valid[IDX_WIDTH'(v_idx)]) begin
        o_winner = IDX_WIDTH'(v_idx);
        v_found  = 1'b1;
      end
      v_idx = rr_next(v_idx, NUM_INPUTS);
    end
    o_any = v_found;
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// rtl/axis_packet_arbiter.sv - packet-granular round-robin AXIS arbiter with one output register stage
// Optional saturating per-input packet counters under AXIS_ARB_STATS_EN.
module axis_packet_arbiter
  import axis_noc_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int TDATA_WIDTH = 32,
  parameter int TDEST_WIDTH = 2,
  parameter int TID_WIDTH   = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axis_packet_arbiter_if.slave   bus
`ifdef AXIS_ARB_STATS_EN
  ,
  output logic [COUNT_WIDTH-1:0] sent_packets [NUM_INPUTS]
`endif
);

  localparam int IW = $clog2(NUM_INPUTS);
  localparam logic [0:0] ST_IDLE   = ARB_IDLE;
  localparam logic [0:0] ST_LOCKED = ARB_LOCKED;

  if (NUM_INPUTS < 2 || NUM_INPUTS > 16 || COUNT_WIDTH < 1) begin : g_bad_params
    $error("axis_packet_arbiter: unsupported parameter set");
  end

  logic [0:0]             r_state;
  logic [IW-1:0]          r_gnt;
  logic [IW-1:0]          r_last;
  logic                   r_out_valid;
  logic [TDATA_WIDTH-1:0] r_out_tdata;
  logic                   r_out_tlast;
  logic [TID_WIDTH-1:0]   r_out_tid;
  logic [TDEST_WIDTH-1:0] r_out_tdest;

  logic [IW-1:0] w_winner;
  logic [IW-1:0] w_sel;
  logic          w_any;
  logic          w_out_ready;
  logic          w_grant_open;
  logic          w_accept;

  axis_rr_select #(
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_WIDTH  (IW)
  ) u_rr_select (
    .i_valid  (bus.axis_in_tvalid),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // A locked grant keeps its tready even while the owner idles, so nobody else slips in.
  assign w_out_ready  = !r_out_valid || bus.axis_out_tready;
  assign w_sel        = (r_state == ST_LOCKED) ? r_gnt : w_winner;
  assign w_grant_open = rst_n && w_out_ready && ((r_state == ST_LOCKED) || w_any);
  assign w_accept     = w_grant_open && bus.axis_in_tvalid[w_sel];

  always_comb begin
    bus.axis_in_tready = '0;
    if (w_grant_open) bus.axis_in_tready[w_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_last      <= IW'(NUM_INPUTS - 1);
      r_out_valid <= 1'b0;
      r_out_tdata <= '0;
      r_out_tlast <= 1'b0;
      r_out_tid   <= '0;
      r_out_tdest <= '0;
    end else begin
      if (w_out_ready) r_out_valid <= w_accept;
      if (w_accept) begin
        r_out_tdata <= bus.axis_in_tdata[w_sel];
        r_out_tlast <= bus.axis_in_tlast[w_sel];
        r_out_tid   <= bus.axis_in_tid[w_sel];
        r_out_tdest <= bus.axis_in_tdest[w_sel];
        r_gnt       <= w_sel;
        r_state     <= bus.axis_in_tlast[w_sel] ? ST_IDLE : ST_LOCKED;
        if (r_state == ST_IDLE) r_last <= w_sel;
      end
    end
  end

  assign bus.axis_out_tvalid = r_out_valid;
  assign bus.axis_out_tdata  = r_out_tdata;
  assign bus.axis_out_tlast  = r_out_tlast;
  assign bus.axis_out_tid    = r_out_tid;
  assign bus.axis_out_tdest  = r_out_tdest;

`ifdef AXIS_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_stats
    logic [COUNT_WIDTH-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_accept && (w_sel == IW'(gi)) && bus.axis_in_tlast[gi] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
    assign sent_packets[gi] = r_cnt;
  end
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb/tb_axis_packet_arbiter.sv - directed bench for axis_packet_arbiter (stats checks under AXIS_ARB_STATS_EN)
module tb_axis_packet_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 4;

  typedef struct packed {
    logic          v;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [1:0]    id;
    logic [1:0]    dest;
    int            cyc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_packet_arbiter_if #(.NUM_INPUTS(N), .TDATA_WIDTH(DW), .TDEST_WIDTH(2), .TID_WIDTH(2)) bus ();

`ifdef AXIS_ARB_STATS_EN
  logic [CW-1:0] sent_packets [N];
`endif

  axis_packet_arbiter #(
    .NUM_INPUTS (N),
    .TDATA_WIDTH(DW),
    .TDEST_WIDTH(2),
    .TID_WIDTH  (2),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef AXIS_ARB_STATS_EN
    , .sent_packets(sent_packets)
`endif
  );

  beat_t        q_in [N][$];
  obs_t         obs[$];
  obs_t         exp_q[$];
  bit           ordy_q[$];
  int           cyc = 0;
  int           first_acc = -1;
  int           first_rdy [N];
  int           tl_acc [N];
  int           stall_cnt = 0;
  int           bad_rdy = 0;
  logic [N-1:0] allow_mask = '1;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bench engine: sample on negedge, advance per-input beat queues after posedge.
  initial begin : engine
    logic [N-1:0]  acc;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    bus.axis_in_tvalid  = '0;
    bus.axis_in_tlast   = '0;
    bus.axis_out_tready = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.axis_in_tdata[i] = '0;
      bus.axis_in_tid[i]   = 2'(i);
      bus.axis_in_tdest[i] = 2'(3 - i);
    end
    forever begin
      @(negedge clk);
      acc = bus.axis_in_tvalid & bus.axis_in_tready;
      if (prev_stall)
        check_eq("stall_hold", 64'({bus.axis_out_tvalid, bus.axis_out_tdata}), 64'({1'b1, prev_data}));
      prev_stall = bus.axis_out_tvalid && !bus.axis_out_tready;
      prev_data  = bus.axis_out_tdata;
      if (prev_stall) stall_cnt++;
      if (bus.axis_out_tvalid && bus.axis_out_tready)
        obs.push_back('{data: bus.axis_out_tdata, last: bus.axis_out_tlast,
                        id: bus.axis_out_tid, dest: bus.axis_out_tdest, cyc: cyc});
      if ((bus.axis_in_tready & ~allow_mask) != '0) bad_rdy++;
      for (int i = 0; i < N; i++) begin
        if (bus.axis_in_tready[i] && first_rdy[i] < 0) first_rdy[i] = cyc;
        if (acc[i] && bus.axis_in_tlast[i]) tl_acc[i] = cyc;
      end
      if (acc != '0 && first_acc < 0) first_acc = cyc;
      @(posedge clk);
      #1;
      cyc++;
      bus.axis_out_tready = (ordy_q.size() > 0) ? ordy_q.pop_front() : 1'b1;
      for (int i = 0; i < N; i++) begin
        if (q_in[i].size() > 0 && (acc[i] || !q_in[i][0].v)) void'(q_in[i].pop_front());
        if (q_in[i].size() > 0) begin
          bus.axis_in_tvalid[i] = q_in[i][0].v;
          bus.axis_in_tlast[i]  = q_in[i][0].last;
          bus.axis_in_tdata[i]  = q_in[i][0].data;
        end else begin
          bus.axis_in_tvalid[i] = 1'b0;
          bus.axis_in_tlast[i]  = 1'b0;
        end
      end
    end
  end

  task automatic send(input int src, input int pkt, input int nbeats, input int gap_after = -1, input int gap = 0);
    for (int b = 0; b < nbeats; b++) begin
      q_in[src].push_back('{v: 1'b1, last: (b == nbeats - 1), data: DW'(src * 65536 + pkt * 256 + b)});
      if (b == gap_after)
        for (int g = 0; g < gap; g++) q_in[src].push_back('{v: 1'b0, last: 1'b0, data: '0});
    end
  endtask

  task automatic expect_pkt(input int src, input int pkt, input int nbeats);
    for (int b = 0; b < nbeats; b++)
      exp_q.push_back('{data: DW'(src * 65536 + pkt * 256 + b), last: (b == nbeats - 1),
                        id: 2'(src), dest: 2'(3 - src), cyc: 0});
  endtask

  task automatic clear_obs();
    obs.delete();
    exp_q.delete();
    first_acc = -1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    bit busy;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      busy = bus.axis_out_tvalid || (ordy_q.size() != 0);
      for (int i = 0; i < N; i++) if (q_in[i].size() != 0) busy = 1'b1;
    end while (busy && n < 500);
    check_eq({tag, "_timeout"}, 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_obs(input string tag);
    check_eq({tag, "_count"}, 64'(obs.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < obs.size(); k++)
      check_eq($sformatf("%s_beat%0d", tag, k),
               64'({obs[k].data, obs[k].last, obs[k].id, obs[k].dest}),
               64'({exp_q[k].data, exp_q[k].last, exp_q[k].id, exp_q[k].dest}));
  endtask

  initial begin : test
    for (int i = 0; i < N; i++) begin
      first_rdy[i] = -1;
      tl_acc[i]    = -1;
    end

    // All four inputs offer a packet while still in reset: nothing may be accepted.
    for (int s = 0; s < N; s++) begin
      send(s, 0, 3);
      expect_pkt(s, 0, 3);
    end
    repeat (3) @(negedge clk);
    check_eq("rst_out_tvalid", 64'(bus.axis_out_tvalid), 64'(0));
    check_eq("rst_in_tready", 64'(bus.axis_in_tready), 64'(0));
    check_eq("rst_in_tvalid_seen", 64'(bus.axis_in_tvalid), 64'(4'hf));
`ifdef AXIS_ARB_STATS_EN
    check_eq("rst_stats0", 64'(sent_packets[0]), 64'(0));
`endif
    @(posedge clk);
    #2 rst_n = 1'b1;

    wait_idle("s1");
    compare_obs("s1");
    if (obs.size() == 12) check_eq("s1_span", 64'(obs[11].cyc - obs[0].cyc), 64'(11));
    if (obs.size() > 0) check_eq("s1_latency", 64'(obs[0].cyc - first_acc), 64'(1));

    // Input 2 alone: back-to-back single-beat packets, no other tready.
    clear_obs();
    allow_mask = 4'b0100;
    bad_rdy = 0;
    for (int p = 0; p < 6; p++) begin
      send(2, p, 1);
      expect_pkt(2, p, 1);
    end
    wait_idle("s2");
    compare_obs("s2");
    if (obs.size() == 6) check_eq("s2_span", 64'(obs[5].cyc - obs[0].cyc), 64'(5));
    check_eq("s2_other_tready", 64'(bad_rdy), 64'(0));
    allow_mask = '1;

    // last=2 now, so 3 must beat 1 when both arrive together.
    clear_obs();
    send(1, 7, 1);
    send(3, 7, 1);
    expect_pkt(3, 7, 1);
    expect_pkt(1, 7, 1);
    wait_idle("s2b");
    compare_obs("s2b");

    // Input 1 stalls mid-packet; input 3 must wait for its tlast.
    clear_obs();
    first_rdy[3] = -1;
    send(1, 1, 3, 0, 5);
    repeat (2) @(negedge clk);
    send(3, 1, 1);
    expect_pkt(1, 1, 3);
    expect_pkt(3, 1, 1);
    wait_idle("s3");
    compare_obs("s3");
    check_eq("s3_rdy3_after_tlast1", 64'(first_rdy[3] - tl_acc[1]), 64'(1));

    // Output backpressure 1,0,0,1 across a 4-beat packet.
    clear_obs();
    stall_cnt = 0;
    ordy_q = '{1'b1, 1'b0, 1'b0, 1'b1};
    send(0, 2, 4);
    expect_pkt(0, 2, 4);
    wait_idle("s4");
    compare_obs("s4");
    check_eq("s4_stall_cycles", 64'(stall_cnt), 64'(2));

    // Reset mid-packet drops the partial packet; afterwards index 0 wins first.
    send(1, 3, 4);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    for (int i = 0; i < N; i++) q_in[i].delete();
    repeat (2) @(negedge clk);
    check_eq("s5_rst_out_tvalid", 64'(bus.axis_out_tvalid), 64'(0));
    clear_obs();
    send(3, 5, 2);
    send(3, 6, 2);
    send(0, 4, 1);
    expect_pkt(0, 4, 1);
    expect_pkt(3, 5, 2);
    expect_pkt(3, 6, 2);
    repeat (2) @(negedge clk);
    check_eq("s5_rst_in_tready", 64'(bus.axis_in_tready), 64'(0));
    check_eq("s5_rst_out_tvalid2", 64'(bus.axis_out_tvalid), 64'(0));
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_idle("s5");
    compare_obs("s5");
`ifdef AXIS_ARB_STATS_EN
    check_eq("s5_stats3", 64'(sent_packets[3]), 64'(2));
    check_eq("s5_stats0", 64'(sent_packets[0]), 64'(1));
    clear_obs();
    for (int p = 0; p < 20; p++) send(0, 16 + p, 1);
    wait_idle("s6");
    check_eq("s6_stats0_sat", 64'(sent_packets[0]), 64'(15));
    check_eq("s6_stats3_hold", 64'(sent_packets[3]), 64'(2));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
